// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined integer ALU with valid/ready handshakes on
// both sides, synchronous flush and an architectural ZF/SF/OF register.
// S1 holds the operands. S2 holds the computed result and flags.
module alu_pipe #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             set_cc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             sign,
  output logic             overflow,
  output logic             carry,
  output logic             cc_zf,
  output logic             cc_sf,
  output logic             cc_of
);

  localparam int unsigned SHW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_AND   = 3'd2,
    OP_XOR   = 3'd3,
    OP_OR    = 3'd4,
    OP_SHL   = 3'd5,
    OP_SAR   = 3'd6,
    OP_PASSB = 3'd7
  } op_e;

  // Stage 1 (operand) registers
  logic             r_s1_valid;
  op_e              r_s1_op;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic             r_s1_setcc;

  // Stage 2 (result) registers
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_res;
  logic             r_zero;
  logic             r_sign;
  logic             r_ovf;
  logic             r_carry;
  logic             r_s2_setcc;

  // Architectural condition codes
  logic             r_cc_zf;
  logic             r_cc_sf;
  logic             r_cc_of;

  // Handshake / control
  logic             w_s2_adv;
  logic             w_s1_adv;
  logic             w_retire;

  // Execute datapath
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_dif;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_res;
  logic             w_ovf;
  logic             w_carry;

  assign w_s2_adv = !r_s2_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign in_ready = w_s1_adv && !flush;
  assign w_retire = r_s2_valid && out_ready && !flush;

  // Compute result and flags for the op currently held in S1
  always_comb begin
    w_sum   = {1'b0, r_s1_a} + {1'b0, r_s1_b};
    w_dif   = {1'b0, r_s1_a} - {1'b0, r_s1_b};
    w_shamt = r_s1_b[SHW-1:0];
    w_res   = '0;
    w_ovf   = 1'b0;
    w_carry = 1'b0;
    case (r_s1_op)
      OP_ADD: begin
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
        w_ovf   = (r_s1_a[WIDTH-1] == r_s1_b[WIDTH-1]) &&
                  (w_sum[WIDTH-1] != r_s1_a[WIDTH-1]);
      end
      OP_SUB: begin
        // bit WIDTH of the zero-extended difference is the unsigned borrow
        w_res   = w_dif[WIDTH-1:0];
        w_carry = w_dif[WIDTH];
        w_ovf   = (r_s1_a[WIDTH-1] != r_s1_b[WIDTH-1]) &&
                  (w_dif[WIDTH-1] != r_s1_a[WIDTH-1]);
      end
      OP_AND:   w_res = r_s1_a & r_s1_b;
      OP_XOR:   w_res = r_s1_a ^ r_s1_b;
      OP_OR:    w_res = r_s1_a | r_s1_b;
      OP_SHL:   w_res = r_s1_a << w_shamt;
      OP_SAR:   w_res = $signed(r_s1_a) >>> w_shamt;
      OP_PASSB: w_res = r_s1_b;
      default:  w_res = '0;
    endcase
  end

  // S1: capture an accepted operand beat; flush empties the stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= OP_ADD;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_setcc <= 1'b0;
    end else if (flush) begin
      r_s1_valid <= 1'b0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_op    <= op_e'(opcode);
        r_s1_a     <= a;
        r_s1_b     <= b;
        r_s1_setcc <= set_cc;
      end
    end
  end

  // S2: register result/flags when S1 moves forward; hold while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_res      <= '0;
      r_zero     <= 1'b0;
      r_sign     <= 1'b0;
      r_ovf      <= 1'b0;
      r_carry    <= 1'b0;
      r_s2_setcc <= 1'b0;
    end else if (flush) begin
      r_s2_valid <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_res      <= w_res;
        r_zero     <= (w_res == '0);
        r_sign     <= w_res[WIDTH-1];
        r_ovf      <= w_ovf;
        r_carry    <= w_carry;
        r_s2_setcc <= r_s1_setcc;
      end
    end
  end

  // Condition codes: update only from a retiring beat that requests it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cc_zf <= 1'b1;
      r_cc_sf <= 1'b0;
      r_cc_of <= 1'b0;
    end else if (w_retire && r_s2_setcc) begin
      r_cc_zf <= r_zero;
      r_cc_sf <= r_sign;
      r_cc_of <= r_ovf;
    end
  end

  assign out_valid = r_s2_valid;
  assign res       = r_res;
  assign zero      = r_zero;
  assign sign      = r_sign;
  assign overflow  = r_ovf;
  assign carry     = r_carry;
  assign cc_zf     = r_cc_zf;
  assign cc_sf     = r_cc_sf;
  assign cc_of     = r_cc_of;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: a 64-bit instance for arithmetic, handshake,
// CC and flush behaviour, plus an 8-bit instance for logic/shift vectors.
module tb_alu_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // 64-bit instance
  logic        flush, in_valid, in_ready, set_cc, out_valid, out_ready;
  logic [2:0]  opcode;
  logic [63:0] a, b, res;
  logic        zero, sign, overflow, carry, cc_zf, cc_sf, cc_of;

  // 8-bit instance
  logic        f8, v8, rdy8, sc8, ov8, ordy8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, res8;
  logic        z8, s8, o8, c8, czf8, csf8, cof8;

  alu_pipe #(.WIDTH(64)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .opcode(opcode), .a(a), .b(b), .set_cc(set_cc),
    .out_valid(out_valid), .out_ready(out_ready), .res(res), .zero(zero),
    .sign(sign), .overflow(overflow), .carry(carry), .cc_zf(cc_zf),
    .cc_sf(cc_sf), .cc_of(cc_of)
  );

  alu_pipe #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .flush(f8), .in_valid(v8),
    .in_ready(rdy8), .opcode(op8), .a(a8), .b(b8), .set_cc(sc8),
    .out_valid(ov8), .out_ready(ordy8), .res(res8), .zero(z8),
    .sign(s8), .overflow(o8), .carry(c8), .cc_zf(czf8),
    .cc_sf(csf8), .cc_of(cof8)
  );

  typedef struct packed {
    logic [63:0] res;
    logic [3:0]  fl;   // {zero, sign, overflow, carry}
    logic        sc;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  q8[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic        m_zf = 1'b1, m_sf = 1'b0, m_of = 1'b0;
  logic        last_in_ready;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [63:0] x,
                                 input logic [63:0] y, input logic sc);
    exp_t        e;
    logic [64:0] t;
    logic        o, c;
    e.res = '0;
    o = 1'b0;
    c = 1'b0;
    case (op)
      3'd0: begin
        t = {1'b0, x} + {1'b0, y};
        e.res = t[63:0];
        c = t[64];
        o = (x[63] == y[63]) && (e.res[63] != x[63]);
      end
      3'd1: begin
        e.res = x - y;
        c = (x < y);
        o = (x[63] != y[63]) && (e.res[63] != x[63]);
      end
      3'd2: e.res = x & y;
      3'd3: e.res = x ^ y;
      3'd4: e.res = x | y;
      3'd5: e.res = x << y[5:0];
      3'd6: e.res = $signed(x) >>> y[5:0];
      default: e.res = y;
    endcase
    e.fl = {(e.res == 64'd0), e.res[63], o, c};
    e.sc = sc;
    return e;
  endfunction

  // One clock cycle on the 64-bit instance: drive, then score what is visible
  task automatic step(input bit v, input logic [2:0] op, input logic [63:0] x,
                      input logic [63:0] y, input bit sc, input bit ordy, input bit fl);
    exp_t e;
    @(negedge clk);
    check("cc", {61'd0, cc_zf, cc_sf, cc_of}, {61'd0, m_zf, m_sf, m_of});
    in_valid = v; opcode = op; a = x; b = y; set_cc = sc;
    out_ready = ordy; flush = fl;
    #1;
    last_in_ready = in_ready;
    if (out_valid) begin
      if (q.size() == 0) begin
        check("spurious_out_valid", {63'd0, out_valid}, 64'd0);
      end else begin
        check("res", res, q[0].res);
        check("flags", {60'd0, zero, sign, overflow, carry}, {60'd0, q[0].fl});
        if (out_ready && !fl) begin
          e = q.pop_front();
          if (e.sc) begin
            m_zf = e.fl[3];
            m_sf = e.fl[2];
            m_of = e.fl[1];
          end
        end
      end
    end
    if (fl) q.delete();
    if (v && in_ready) q.push_back(model(op, x, y, sc));
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() > 0; i++)
      step(1'b0, 3'd0, 64'd0, 64'd0, 1'b0, 1'b1, 1'b0);
    check("drain_empty", 64'(q.size()), 64'd0);
  endtask

  // Single beat through the 8-bit instance with a fixed expected result
  task automatic run8(input string tag, input logic [2:0] op, input logic [7:0] x,
                      input logic [7:0] y, input logic [7:0] exp);
    bit got;
    @(negedge clk);
    v8 = 1'b1; op8 = op; a8 = x; b8 = y;
    #1;
    if (rdy8) q8.push_back(exp);
    @(negedge clk);
    v8 = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 8 && !got; n++) begin
      #1;
      if (ov8) begin
        if (q8.size() == 0) check({tag, "_noexp"}, {63'd0, ov8}, 64'd0);
        else check(tag, {56'd0, res8}, {56'd0, q8.pop_front()});
        got = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!got) check({tag, "_timeout"}, {63'd0, ov8}, 64'd1);
  endtask

  logic [63:0] ra, rb;
  logic [2:0]  rop;
  bit          rsc;
  int          sent;

  initial begin
    rst_n = 1'b0;
    flush = 1'b0; in_valid = 1'b0; opcode = '0; a = '0; b = '0;
    set_cc = 1'b0; out_ready = 1'b1;
    f8 = 1'b0; v8 = 1'b0; op8 = '0; a8 = '0; b8 = '0; sc8 = 1'b0; ordy8 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'd4);

    // Arithmetic flag corners, issued back to back
    step(1'b1, 3'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 3'd1, 64'd5, 64'd5, 1'b0, 1'b1, 1'b0);
    step(1'b1, 3'd1, 64'd0, 64'd1, 1'b0, 1'b1, 1'b0);
    drain();

    // CC gating
    step(1'b1, 3'd1, 64'd3, 64'd3, 1'b1, 1'b1, 1'b0);
    drain();
    step(1'b0, 3'd0, 64'd0, 64'd0, 1'b0, 1'b1, 1'b0);
    check("cc_zf_sub", {63'd0, cc_zf}, 64'd1);
    step(1'b1, 3'd0, 64'd1, 64'd1, 1'b0, 1'b1, 1'b0);
    drain();
    step(1'b0, 3'd0, 64'd0, 64'd0, 1'b0, 1'b1, 1'b0);
    check("cc_zf_hold", {63'd0, cc_zf}, 64'd1);
    step(1'b1, 3'd0, 64'd1, 64'd1, 1'b1, 1'b1, 1'b0);
    drain();
    step(1'b0, 3'd0, 64'd0, 64'd0, 1'b0, 1'b1, 1'b0);
    check("cc_zf_add", {63'd0, cc_zf}, 64'd0);

    // Back-pressure: 10 beats, each held until accepted, random out_ready
    sent = 0;
    rop = 3'($urandom_range(0, 7)); ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
    rsc = 1'($urandom_range(0, 1));
    for (int cyc = 0; cyc < 300 && sent < 10; cyc++) begin
      step(1'b1, rop, ra, rb, rsc, 1'($urandom_range(0, 1)), 1'b0);
      if (last_in_ready) begin
        sent++;
        rop = 3'($urandom_range(0, 7)); ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
        rsc = 1'($urandom_range(0, 1));
      end
    end
    check("bp_sent", 64'(sent), 64'd10);
    drain();

    // Flush with both stages full of CC-setting SUBs
    step(1'b1, 3'd1, 64'd7, 64'd7, 1'b1, 1'b0, 1'b0);
    step(1'b1, 3'd1, 64'd9, 64'd9, 1'b1, 1'b0, 1'b0);
    step(1'b1, 3'd1, 64'd2, 64'd2, 1'b1, 1'b1, 1'b1);
    check("flush_in_ready", {63'd0, last_in_ready}, 64'd0);
    step(1'b0, 3'd0, 64'd0, 64'd0, 1'b0, 1'b1, 1'b0);
    check("flush_out_valid", {63'd0, out_valid}, 64'd0);
    step(1'b0, 3'd0, 64'd0, 64'd0, 1'b0, 1'b1, 1'b0);

    // Logic/shift vectors on the 8-bit build
    run8("xor8", 3'd3, 8'h0B, 8'h2A, 8'h21);
    run8("sar8", 3'd6, 8'h80, 8'd3, 8'hF0);
    run8("shl8", 3'd5, 8'h81, 8'd9, 8'h02);
    run8("passb8", 3'd7, 8'h00, 8'h5A, 8'h5A);

    // Asynchronous reset mid-stream
    step(1'b1, 3'd0, 64'd10, 64'd20, 1'b1, 1'b0, 1'b0);
    step(1'b1, 3'd0, 64'd30, 64'd40, 1'b1, 1'b0, 1'b0);
    step(1'b0, 3'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'd4);
    q.delete();
    m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 3'd4, 64'h00F0, 64'h0F00, 1'b1, 1'b1, 1'b0);
    drain();
    step(1'b0, 3'd0, 64'd0, 64'd0, 1'b0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
